// File: rtl/simproc_ctrl.sv
// simproc_ctrl: multi-cycle control and register stage of the 8-bit simple
// processor. Owns PC, IR, R0-R3 and the N/Z flags, fetches over a
// single-outstanding req/ack memory port and sequences the external ALU.
// Optional debug access (register peek, single-step out of HALT) is enabled
// by defining SIMPROC_CTRL_DBG_EN.
module simproc_ctrl #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    output logic [2:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_out,
    input  logic       alu_n,
    input  logic       alu_z,
    output logic [7:0] pc,
    output logic       flag_n,
    output logic       flag_z,
    output logic       halted
`ifdef SIMPROC_CTRL_DBG_EN
    ,
    input  logic [1:0] dbg_sel,
    output logic [7:0] dbg_data,
    input  logic       dbg_step
`endif
);

    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_BZ   = 4'h9;
    localparam logic [3:0] OP_BNZ  = 4'hA;
    localparam logic [3:0] OP_BN   = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_IMM,
        S_HALT
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic [7:0] r_pc;
    logic [7:0] r_ir;
    logic [7:0] r_regs [4];
    logic       r_flag_n;
    logic       r_flag_z;

    logic [3:0] w_opcode;
    logic [1:0] w_rx;
    logic [1:0] w_ry;
    logic [7:0] w_rx_val;
    logic [7:0] w_ry_val;
    logic       w_taken;

    logic [7:0] w_pc_next;
    logic       w_ir_load;
    logic       w_reg_we;
    logic [7:0] w_reg_wdata;
    logic       w_flag_we;

    assign w_opcode = r_ir[3:0];
    assign w_rx     = r_ir[5:4];
    assign w_ry     = r_ir[7:6];
    assign w_rx_val = r_regs[w_rx];
    assign w_ry_val = r_regs[w_ry];

    assign pc     = r_pc;
    assign flag_n = r_flag_n;
    assign flag_z = r_flag_z;
    assign halted = (r_state == S_HALT);

`ifdef SIMPROC_CTRL_DBG_EN
    assign dbg_data = r_regs[dbg_sel];
`endif

    // Branch condition for the immediate-operand instructions.
    always_comb begin
        w_taken = 1'b0;
        case (w_opcode)
            OP_BZ:   w_taken = r_flag_z;
            OP_BNZ:  w_taken = ~r_flag_z;
            OP_BN:   w_taken = r_flag_n;
            OP_JMP:  w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, datapath write controls and bus/ALU outputs.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_ir_load    = 1'b0;
        w_reg_we     = 1'b0;
        w_reg_wdata  = '0;
        w_flag_we    = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        alu_op       = '0;
        alu_a        = '0;
        alu_b        = '0;

        case (r_state)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = r_pc;
                if (mem_ack) begin
                    w_ir_load    = 1'b1;
                    w_pc_next    = r_pc + 8'd1;
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                case (w_opcode)
                    4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5:
                        w_state_next = S_EXEC;
                    OP_LD, OP_ST:
                        w_state_next = S_MEM;
                    OP_LDI, OP_BZ, OP_BNZ, OP_BN, OP_JMP:
                        w_state_next = S_IMM;
                    OP_HALT:
                        w_state_next = S_HALT;
                    default:
                        w_state_next = S_FETCH;
                endcase
            end
            S_EXEC: begin
                alu_op       = r_ir[2:0];
                alu_a        = w_rx_val;
                alu_b        = w_ry_val;
                w_reg_we     = 1'b1;
                w_reg_wdata  = alu_out;
                w_flag_we    = 1'b1;
                w_state_next = S_FETCH;
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_we    = (w_opcode == OP_ST);
                mem_addr  = w_ry_val;
                mem_wdata = w_rx_val;
                if (mem_ack) begin
                    if (w_opcode == OP_LD) begin
                        w_reg_we    = 1'b1;
                        w_reg_wdata = mem_rdata;
                    end
                    w_state_next = S_FETCH;
                end
            end
            S_IMM: begin
                mem_req  = 1'b1;
                mem_addr = r_pc;
                if (mem_ack) begin
                    if (w_opcode == OP_LDI) begin
                        w_reg_we    = 1'b1;
                        w_reg_wdata = mem_rdata;
                        w_pc_next   = r_pc + 8'd1;
                    end else if (w_taken) begin
                        w_pc_next   = mem_rdata;
                    end else begin
                        w_pc_next   = r_pc + 8'd1;
                    end
                    w_state_next = S_FETCH;
                end
            end
            S_HALT: begin
`ifdef SIMPROC_CTRL_DBG_EN
                if (dbg_step) begin
                    w_state_next = S_FETCH;
                end
`endif
            end
            default: begin
                w_state_next = S_FETCH;
            end
        endcase

        // The state flop already sits in FETCH during reset; masking the bus
        // here drops an outstanding request the moment rst rises.
        if (rst) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    // PC, IR, register file and flag updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_flag_n <= 1'b0;
            r_flag_z <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_pc <= w_pc_next;
            if (w_ir_load) begin
                r_ir <= mem_rdata;
            end
            if (w_reg_we) begin
                r_regs[w_rx] <= w_reg_wdata;
            end
            if (w_flag_we) begin
                r_flag_n <= alu_n;
                r_flag_z <= alu_z;
            end
        end
    end

endmodule

// File: tb/tb_simproc_ctrl.sv
// Directed testbench for simproc_ctrl with a behavioural memory (configurable
// wait states, stray-ack injection) and a behavioural ALU.
module tb_simproc_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_ack = 1'b0;
    logic [2:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_out;
    logic       alu_n;
    logic       alu_z;
    logic [7:0] pc;
    logic       flag_n;
    logic       flag_z;
    logic       halted;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] mem [256];
    int   wait_cfg = 0;
    bit   stray    = 1'b0;
    bit   busy     = 1'b0;
    int   wl       = 0;
    int   st_cnt   = 0;
    logic [7:0] last_st_addr = 8'h00;
    logic [7:0] last_st_data = 8'h00;
    int   wr_cycles = 0;
    int   st80_good = 0;
    logic [2:0] cap_op = 3'd0;
    logic [7:0] cap_a  = 8'h00;
    logic [7:0] cap_b  = 8'h00;

    simproc_ctrl #(.RESET_PC(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_out   (alu_out),
        .alu_n     (alu_n),
        .alu_z     (alu_z),
        .pc        (pc),
        .flag_n    (flag_n),
        .flag_z    (flag_z),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // Behavioural ALU.
    always_comb begin
        case (alu_op)
            3'd0:    alu_out = alu_a + alu_b;
            3'd1:    alu_out = alu_a - alu_b;
            3'd2:    alu_out = alu_a | alu_b;
            3'd3:    alu_out = ~(alu_a & alu_b);
            3'd4:    alu_out = {alu_a[6:0], 1'b0};
            3'd5:    alu_out = {1'b0, alu_a[7:1]};
            default: alu_out = 8'h00;
        endcase
        alu_n = alu_out[7];
        alu_z = (alu_out == 8'h00);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory: decides ack on the falling edge, wait_cfg idle cycles per transaction.
    always @(negedge clk) begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        if (stray) begin
            mem_ack   = 1'b1;
            mem_rdata = 8'hFF;
            busy      = 1'b0;
        end else if (rst || !mem_req) begin
            busy = 1'b0;
        end else begin
            if (!busy) begin
                busy = 1'b1;
                wl   = wait_cfg;
            end
            if (wl == 0) begin
                mem_ack = 1'b1;
                busy    = 1'b0;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    st_cnt++;
                    last_st_addr = mem_addr;
                    last_st_data = mem_wdata;
                end else begin
                    mem_rdata = mem[mem_addr];
                end
            end else begin
                wl--;
            end
        end
    end

    // Bus/ALU observation on the falling edge.
    always @(negedge clk) begin
        if (!mem_req) begin
            chk("idle_bus_zero", {15'd0, mem_we, mem_addr, mem_wdata}, 32'd0);
        end
        if (mem_req && mem_we) begin
            wr_cycles++;
            if (mem_addr == 8'h80 && mem_wdata == 8'hAA) st80_good++;
        end
        if (alu_op != 3'd0 || alu_a != 8'h00 || alu_b != 8'h00) begin
            cap_op = alu_op;
            cap_a  = alu_a;
            cap_b  = alu_b;
        end
    end

    task automatic clear_mem;
        for (int i = 0; i < 256; i++) mem[i] = 8'h0F;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_halt(input int budget, output int cycles);
        cycles = 0;
        while (halted !== 1'b1 && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int cyc2;

        // ---- Reset state and first fetch; LDI/LDI/ADD/LDI/ST/HALT ----
        clear_mem();
        mem[8'h00] = 8'h08; mem[8'h01] = 8'h05;   // LDI R0,5
        mem[8'h02] = 8'h18; mem[8'h03] = 8'h03;   // LDI R1,3
        mem[8'h04] = 8'h40;                       // ADD R0,R1
        mem[8'h05] = 8'h38; mem[8'h06] = 8'hF0;   // LDI R3,F0
        mem[8'h07] = 8'hC7;                       // ST R0,[R3]
        mem[8'h08] = 8'h0F;                       // HALT
        wait_cfg = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_pc", pc, 8'h00);
        chk("rst_flags", {flag_n, flag_z}, 2'b00);
        chk("rst_halted", halted, 0);
        chk("rst_alu", {alu_op, alu_a, alu_b}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("t1_first_req", mem_req, 1);
        chk("t1_first_addr", mem_addr, 8'h00);
        chk("t1_first_we", mem_we, 0);
        @(posedge clk);
        #1;
        chk("t1_pc_after_ack", pc, 8'h01);
        chk("t1_decode_no_req", mem_req, 0);
        run_halt(200, cyc);
        chk("t1_halted", halted, 1);
        chk("t1_cycles", cyc + 1, 17);
        chk("t1_pc", pc, 8'h09);
        chk("t1_flags", {flag_n, flag_z}, 2'b00);
        chk("t1_exec_op", cap_op, 3'd0);
        chk("t1_exec_a", cap_a, 8'h05);
        chk("t1_exec_b", cap_b, 8'h03);
        chk("t1_r0_stored", mem[8'hF0], 8'h08);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_halt_stays", {halted, mem_req, pc}, {1'b1, 1'b0, 8'h09});
        chk("t1_halt_alu_idle", {alu_op, alu_a, alu_b}, 0);

        // ---- SUB to zero then BZ taken ----
        clear_mem();
        mem[8'h00] = 8'h08; mem[8'h01] = 8'h07;   // LDI R0,7
        mem[8'h02] = 8'h18; mem[8'h03] = 8'h07;   // LDI R1,7
        mem[8'h04] = 8'h41;                       // SUB R0,R1
        mem[8'h05] = 8'h09; mem[8'h06] = 8'h40;   // BZ 40
        mem[8'h07] = 8'h0F;                       // HALT (fall-through)
        mem[8'h40] = 8'h0F;                       // HALT (target)
        do_reset();
        run_halt(200, cyc);
        chk("t2_cycles", cyc, 14);
        chk("t2_pc_taken", pc, 8'h41);
        chk("t2_flag_z", flag_z, 1);
        chk("t2_flag_n", flag_n, 0);
        chk("t2_exec", {cap_op, cap_a, cap_b}, {3'd1, 8'h07, 8'h07});

        // ---- Same with R1=6: BZ not taken ----
        mem[8'h03] = 8'h06;
        do_reset();
        run_halt(200, cyc);
        chk("t2n_cycles", cyc, 14);
        chk("t2n_pc_not_taken", pc, 8'h08);
        chk("t2n_flags", {flag_n, flag_z}, 2'b00);
        chk("t2n_exec", {cap_op, cap_a, cap_b}, {3'd1, 8'h07, 8'h06});

        // ---- ST/LD with three wait states on every transaction ----
        clear_mem();
        mem[8'h00] = 8'h18; mem[8'h01] = 8'h01;   // LDI R1,1
        mem[8'h02] = 8'h41;                       // SUB R0,R1 -> FF, N=1
        mem[8'h03] = 8'h28; mem[8'h04] = 8'hAA;   // LDI R2,AA
        mem[8'h05] = 8'h38; mem[8'h06] = 8'h80;   // LDI R3,80
        mem[8'h07] = 8'hE7;                       // ST R2,[R3]
        mem[8'h08] = 8'hD6;                       // LD R1,[R3]
        mem[8'h09] = 8'h17;                       // ST R1,[R0]
        mem[8'h0A] = 8'h0F;                       // HALT
        wait_cfg  = 3;
        st_cnt    = 0;
        wr_cycles = 0;
        st80_good = 0;
        do_reset();
        cyc = 0;
        while (st_cnt < 1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("t3_first_store_done", st_cnt, 1);
        mem[8'h80] = 8'h5A;
        run_halt(300, cyc2);
        chk("t3_cycles", cyc + cyc2, 65);
        chk("t3_st_stable_cycles", st80_good, 4);
        chk("t3_write_cycles", wr_cycles, 8);
        chk("t3_store_count", st_cnt, 2);
        chk("t3_ld_value", {last_st_addr, last_st_data}, {8'hFF, 8'h5A});
        chk("t3_flags_kept", {flag_n, flag_z}, 2'b10);
        chk("t3_pc", pc, 8'h0B);

        // ---- JMP to FF, NOP at FF, PC wraps to 00 ----
        clear_mem();
        mem[8'h00] = 8'h0C; mem[8'h01] = 8'hFD;   // JMP FD
        mem[8'hFD] = 8'h0C; mem[8'hFE] = 8'hFF;   // JMP FF
        mem[8'hFF] = 8'h0D;                       // NOP
        wait_cfg = 0;
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("t4_pc_fd", pc, 8'hFD);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_pc_ff", pc, 8'hFF);
        @(posedge clk);
        #1;
        chk("t4_pc_wrap", pc, 8'h00);
        @(posedge clk);
        #1;
        chk("t4_fetch_wrap", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'h00});
        chk("t4_not_halted", halted, 0);

        // ---- Async reset during a stalled LD, stray ack in reset ----
        clear_mem();
        mem[8'h00] = 8'h28; mem[8'h01] = 8'hAA;   // LDI R2,AA
        mem[8'h02] = 8'hD6;                       // LD R1,[R3]
        wait_cfg = 0;
        do_reset();
        repeat (4) @(posedge clk);
        #1;
        wait_cfg = 20;
        @(posedge clk);
        #1;
        chk("t5_mem_req", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'h00});
        repeat (2) @(posedge clk);
        #1;
        chk("t5_still_waiting", mem_req, 1);
        rst = 1'b1;
        #1;
        chk("t5_req_drop", mem_req, 0);
        chk("t5_pc_reset", pc, 8'h00);
        chk("t5_halted_reset", halted, 0);
        mem[8'h00] = 8'hE7;                       // ST R2,[R3]
        mem[8'h01] = 8'h0F;                       // HALT
        wait_cfg = 0;
        st_cnt   = 0;
        stray    = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_stray_ignored_pc", pc, 8'h00);
        chk("t5_stray_no_req", mem_req, 0);
        stray = 1'b0;
        rst   = 1'b0;
        run_halt(100, cyc);
        chk("t5_cycles", cyc, 5);
        chk("t5_store_count", st_cnt, 1);
        chk("t5_regs_cleared", {last_st_addr, last_st_data}, {8'h00, 8'h00});
        chk("t5_pc", pc, 8'h02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
